st2bus_pack: RTL and testbench
==============================

ST2BUS_PACK -- requirements
Module: st2bus_pack

Interface
REQ-001 SHALL have parameter ST, default 8, input stream symbol width in bits.
REQ-002 SHALL have parameter OUT_W, default 512, output word width in bits; OUT_W/ST (64) symbols per word.
REQ-003 SHALL have parameter PKT_SYM, default 128, nominal symbols per decoded packet (1024-bit turbo block / 8).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 st_data  input  ST  decoded symbol.
REQ-007 st_valid / st_sop / st_eop  input  1 each  stream qualifiers.
REQ-008 st_ready  output  1  symbol accepted when st_valid && st_ready.
REQ-009 out_data  output  OUT_W  packed word, symbol 0 in bits [ST-1:0].
REQ-010 out_valid / out_sop / out_eop  output  1 each  word qualifiers.
REQ-011 out_nsym  output  7  valid symbols in out_data, 1..64.
REQ-012 out_ready  input  1  word transferred when out_valid && out_ready.
REQ-013 err_framing  output  1  sticky framing-error flag.
REQ-014 pkt_cnt  output  16  count of packets completed at the output, wraps 0xFFFF->0.

Function
REQ-015 FSM SHALL have states IDLE (await sop) and PACK (inside packet).
REQ-016 IDLE: accepted beat with st_sop=1 -> PACK, symbol stored at slot 0; beat without sop SHALL be dropped and set err_framing.
REQ-017 PACK: each accepted beat stored at next slot; slot counter 0..63, wraps to 0 after slot 63.
REQ-018 Word SHALL close on slot-63 write or on st_eop; unused slots SHALL be zero.
REQ-019 Accepted beat with st_sop=1 in PACK SHALL set err_framing and be treated as ordinary data (no restart).
REQ-020 Beat with st_sop=1 and st_eop=1 in IDLE SHALL form a 1-symbol packet: out_sop=out_eop=1, out_nsym=1.
REQ-021 st_eop closes packet: FSM -> IDLE, closed word carries out_eop=1.
REQ-022 First word of a packet SHALL carry out_sop=1; all others 0.
REQ-023 Packet length SHALL NOT be enforced against PKT_SYM; length mismatch is not an error.
REQ-024 Two storage stages: accumulator and output register; closed word moves to output register in the cycle after closing if it is empty or drained that cycle.
REQ-025 Latency: word closed by beat accepted at cycle N SHALL present out_valid at N+1 when output register is free.
REQ-026 st_ready SHALL be 0 only while accumulator holds a closed word and output register is full and not draining; otherwise 1.
REQ-027 out_data/out_sop/out_eop/out_nsym SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Sustained throughput: one symbol per cycle with out_ready=1 continuously.
REQ-029 pkt_cnt SHALL increment on each transferred word with out_eop=1.

Reset
REQ-030 rst=1 SHALL asynchronously force: FSM=IDLE, slot=0, both stages empty, out_valid=0, out_sop=0, out_eop=0, out_nsym=0, out_data=0, err_framing=0, pkt_cnt=0, st_ready=0.
REQ-031 st_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Reset mid-packet SHALL discard all partial and pending words; no output after release until a new sop.

Structure
REQ-033 Shared package SHALL hold ST, OUT_W, PKT_SYM defaults, symbols-per-word constant and FSM state encoding.
REQ-034 Single-module implementation; no sub-modules required.

Verification
REQ-035 128 symbols 0x00..0x7F, sop beat 0, eop beat 127, out_ready=1 -> 2 words, word0 sop=1 nsym=64 bytes 0x00..0x3F, word1 eop=1 nsym=64, pkt_cnt=1.
REQ-036 70-symbol packet -> word1 nsym=6, eop=1, bits [511:48]=0.
REQ-037 out_ready=0 for 200 cycles during 2 back-to-back packets -> st_ready falls after second word closes, no data lost, words released in order when out_ready=1.
REQ-038 Beat without sop in IDLE -> dropped, err_framing=1, no output word; sop inside packet -> err_framing=1, data intact.
REQ-039 Single beat sop=eop=1 data 0xA5 -> one word, nsym=1, sop=eop=1, out_data=0x...00A5.
REQ-040 rst pulse at symbol 40 of packet -> outputs zero at once, no word from aborted packet, next packet packs from slot 0.

Source files
------------

// File: rtl/st2bus_pack_pkg.sv
// Shared constants and FSM encoding for the stream-to-bus packer.
package st2bus_pack_pkg;

    localparam int ST_DEF       = 8;
    localparam int OUT_W_DEF    = 512;
    localparam int PKT_SYM_DEF  = 128;
    localparam int SYM_PER_WORD = OUT_W_DEF / ST_DEF;
    localparam int NSYM_W       = 7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PACK = 1'b1
    } state_e;

endpackage : st2bus_pack_pkg

// File: rtl/st2bus_pack.sv
// Packs a symbol stream into wide bus words with packet framing.
// Stage 1 is the accumulator that fills slot by slot; once a word closes it
// waits there until stage 2 (the output register) can take it.
module st2bus_pack
    import st2bus_pack_pkg::*;
#(
    parameter int ST      = ST_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int PKT_SYM = PKT_SYM_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ST-1:0]      st_data,
    input  logic               st_valid,
    input  logic               st_sop,
    input  logic               st_eop,
    output logic               st_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [NSYM_W-1:0]  out_nsym,
    input  logic               out_ready,
    output logic               err_framing,
    output logic [15:0]        pkt_cnt
);

    localparam int NSYM   = OUT_W / ST;
    localparam int SLOT_W = $clog2(NSYM);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSYM - 1);

    // Packet length is deliberately not policed; PKT_SYM only has to be sane.
    if ((OUT_W % ST) != 0 || NSYM > 64 || NSYM < 2 || PKT_SYM < 1) begin : g_bad_cfg
        $error("st2bus_pack: unsupported ST/OUT_W/PKT_SYM combination");
    end

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                first_q, first_d;      // next closed word opens the packet
    logic [OUT_W-1:0]    acc_data_q, acc_data_d;
    logic                acc_full_q, acc_full_d; // accumulator holds a closed word
    logic                acc_sop_q, acc_sop_d;
    logic                acc_eop_q, acc_eop_d;
    logic [NSYM_W-1:0]   acc_nsym_q, acc_nsym_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [NSYM_W-1:0]   out_nsym_q, out_nsym_d;
    logic                err_q, err_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;
    logic                rdy_en_q;              // holds st_ready low until the first edge after reset

    logic move;      // closed word advances from accumulator to output register
    logic out_fire;  // output word transferred this cycle
    logic ready;
    logic accept;
    logic write;

    // Next-state logic for both storage stages, the FSM and the counters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        slot_d      = slot_q;
        first_d     = first_q;
        acc_data_d  = acc_data_q;
        acc_full_d  = acc_full_q;
        acc_sop_d   = acc_sop_q;
        acc_eop_d   = acc_eop_q;
        acc_nsym_d  = acc_nsym_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_nsym_d  = out_nsym_q;
        err_d       = err_q;
        pkt_cnt_d   = pkt_cnt_q;
        write       = 1'b0;

        out_fire = out_valid_q && out_ready;
        move     = acc_full_q && (!out_valid_q || out_ready);
        ready    = rdy_en_q && (!acc_full_q || move);
        accept   = st_valid && ready;

        // Output stage: drain, then refill from the accumulator.
        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_eop_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
        if (move) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data_q;
            out_sop_d   = acc_sop_q;
            out_eop_d   = acc_eop_q;
            out_nsym_d  = acc_nsym_q;
            acc_full_d  = 1'b0;
        end

        // Framing: only a sop beat opens a packet; stray sop inside is data.
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (st_sop) begin
                        write   = 1'b1;
                        state_d = S_PACK;
                        first_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PACK: begin
                if (accept) begin
                    write = 1'b1;
                    if (st_sop) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accumulator fill; slot 0 wipes the previous word so unused slots read zero.
        if (write) begin
            if (slot_q == '0) begin
                acc_data_d = '0;
            end
            acc_data_d[slot_q*ST +: ST] = st_data;
            if (slot_q == LAST_SLOT || st_eop) begin
                acc_full_d = 1'b1;
                acc_nsym_d = NSYM_W'(slot_q) + NSYM_W'(1);
                acc_sop_d  = (state_q == S_IDLE) || first_q;
                acc_eop_d  = st_eop;
                slot_d     = '0;
                first_d    = 1'b0;
                if (st_eop) begin
                    state_d = S_IDLE;
                end
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    // State registers with asynchronous reset discarding any partial or pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
            state_q     <= S_IDLE;
            slot_q      <= '0;
            first_q     <= 1'b0;
            acc_data_q  <= '0;
            acc_full_q  <= 1'b0;
            acc_sop_q   <= 1'b0;
            acc_eop_q   <= 1'b0;
            acc_nsym_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_nsym_q  <= '0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            first_q     <= first_d;
            acc_data_q  <= acc_data_d;
            acc_full_q  <= acc_full_d;
            acc_sop_q   <= acc_sop_d;
            acc_eop_q   <= acc_eop_d;
            acc_nsym_q  <= acc_nsym_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_nsym_q  <= out_nsym_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign st_ready    = ready;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_nsym    = out_nsym_q;
    assign err_framing = err_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule : st2bus_pack

// File: tb/tb_st2bus_pack.sv
// Directed bench for st2bus_pack with a word scoreboard and output monitor.
module tb_st2bus_pack;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [6:0]   nsym;
    } word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   st_data = '0;
    logic         st_valid = 1'b0;
    logic         st_sop = 1'b0;
    logic         st_eop = 1'b0;
    logic         st_ready;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic [6:0]   out_nsym;
    logic         out_ready = 1'b1;
    logic         err_framing;
    logic [15:0]  pkt_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_pkt  = 0;
    word_t exp_q[$];

    logic         prev_stall = 1'b0;
    logic [522:0] prev_word  = '0;

    st2bus_pack dut (
        .clk        (clk),
        .rst        (rst),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_sop     (st_sop),
        .st_eop     (st_eop),
        .st_ready   (st_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_nsym   (out_nsym),
        .out_ready  (out_ready),
        .err_framing(err_framing),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [522:0] obs, input logic [522:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every transfer; stability check on every stalled cycle.
    always @(negedge clk) begin
        word_t w;
        if (!rst) begin
            if (prev_stall && out_valid) begin
                check("stable_hold", {out_data, out_sop, out_eop, out_nsym}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b1, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", out_data, w.data);
                    check("word_flags", {out_sop, out_eop, out_nsym}, {w.sop, w.eop, w.nsym});
                    if (w.eop) exp_pkt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_data, out_sop, out_eop, out_nsym};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eop);
        logic acc;
        int   waited = 0;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = st_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 1000) begin
                check("beat_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
    endtask

    // Builds the expected words for a packet, then drives its beats.
    task automatic send_packet(input int base, input int len, input int mid_sop);
        word_t w;
        int    slot  = 0;
        logic  first = 1'b1;
        w = '0;
        for (int i = 0; i < len; i++) begin
            w.data[slot*8 +: 8] = 8'(base + i);
            slot++;
            if (slot == 64 || i == len - 1) begin
                w.sop  = first;
                w.eop  = (i == len - 1);
                w.nsym = 7'(slot);
                exp_q.push_back(w);
                first = 1'b0;
                slot  = 0;
                w     = '0;
            end
        end
        for (int i = 0; i < len; i++) begin
            drive_beat(8'(base + i), (i == 0) || (i == mid_sop), i == len - 1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", exp_q.size() == 0 && !out_valid, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        time t0;

        // Reset state
        #2;
        check("rst_st_ready", st_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_fields", {out_data, out_sop, out_eop, out_nsym}, '0);
        check("rst_err", err_framing, 1'b0);
        check("rst_pkt_cnt", pkt_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", st_ready, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after_edge", st_ready, 1'b1);

        // 128-symbol packet at full rate
        t0 = $time;
        send_packet(8'h00, 128, -1);
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd128);
        wait_drain();
        check("pkt_cnt_1", pkt_cnt, 16'd1);
        check("pkt_cnt_model_1", pkt_cnt, 16'(exp_pkt));
        check("err_clean", err_framing, 1'b0);

        // 70-symbol packet: short tail word padded with zeros
        send_packet(8'h80, 70, -1);
        wait_drain();
        check("pkt_cnt_2", pkt_cnt, 16'd2);

        // Single-beat packet and close-to-valid latency
        send_packet(8'hA5, 1, -1);
        check("lat_not_yet", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1'b1);
        check("single_data", out_data, 512'h0A5);
        wait_drain();
        check("pkt_cnt_3", pkt_cnt, 16'd3);

        // Stray beat in IDLE is dropped
        drive_beat(8'h55, 1'b0, 1'b0);
        check("stray_err", err_framing, 1'b1);
        idle_cycles(5);
        check("stray_no_word", out_valid, 1'b0);

        // Reset clears the sticky flag; then a stray sop inside a packet
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_pkt = 0;
        check("rst2_err", err_framing, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(1);
        send_packet(8'h20, 10, 4);
        wait_drain();
        check("mid_sop_err", err_framing, 1'b1);
        check("pkt_cnt_mid_sop", pkt_cnt, 16'd1);

        // Back-pressure: two back-to-back packets with out_ready low
        out_ready = 1'b0;
        fork
            begin
                send_packet(8'h10, 64, -1);
                send_packet(8'h60, 128, -1);
            end
            begin
                idle_cycles(200);
                check("bp_ready_low", st_ready, 1'b0);
                check("bp_out_held", out_valid, 1'b1);
                check("bp_no_count", pkt_cnt, 16'd1);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_pkt_cnt", pkt_cnt, 16'd3);
        check("bp_pkt_model", pkt_cnt, 16'(exp_pkt));

        // Reset mid-packet with a closed word held at the output
        out_ready = 1'b0;
        for (int i = 0; i < 104; i++) begin
            drive_beat(8'(8'hC0 + i), i == 0, 1'b0);
        end
        check("abort_word_held", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_pkt = 0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_fields", {out_data, out_sop, out_eop, out_nsym}, '0);
        check("abort_st_ready", st_ready, 1'b0);
        check("abort_pkt_cnt", pkt_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        idle_cycles(8);
        check("abort_no_output", out_valid, 1'b0);
        send_packet(8'h33, 5, -1);
        wait_drain();
        check("after_abort_cnt", pkt_cnt, 16'd1);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_st2bus_pack
